// File: rtl/sdm_mod_param.sv
// Parametrised 1-bit PDM sigma-delta modulator, order 1 or 2, with saturating
// integrators, optional LFSR dither, a per-frame sample handshake and IDLE/RUN control.
module sdm_mod_param #(
  parameter int          DATA_W    = 16,
  parameter int          ORDER     = 2,
  parameter int          INT_W     = DATA_W + 4,
  parameter int          OSR       = 128,
  parameter bit          DITHER_EN = 1'b1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              running,
  output logic              overload,
  output logic              underrun,
  input  logic              flag_clr
);

  localparam int CW = $clog2(OSR);
  // Two guard bits keep integrator + input - feedback exact before clamping.
  localparam int SW = INT_W + 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CW-1:0]        LAST_CNT = CW'(OSR - 1);
  localparam logic [CW-1:0]        CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] SAT_MAX  = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN  = {3'b111, {(INT_W-1){1'b0}}};
  localparam logic signed [SW-1:0] FB_POS   = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] FB_NEG   = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [SW-1:0] D_POS    = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] D_NEG    = {SW{1'b1}};

  // Returns {clipped, clamped value}.
  function automatic logic [INT_W:0] sat_f(input logic signed [SW-1:0] v);
    logic [INT_W:0] r;
    if (v > SAT_MAX) begin
      r = {1'b1, SAT_MAX[INT_W-1:0]};
    end else if (v < SAT_MIN) begin
      r = {1'b1, SAT_MIN[INT_W-1:0]};
    end else begin
      r = {1'b0, v[INT_W-1:0]};
    end
    return r;
  endfunction

  logic [0:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [INT_W-1:0] i1_q, i1_d, i2_q, i2_d;
  logic [DATA_W-1:0]       held_q, held_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic                    out_q, out_d, ovl_q, ovl_d, udr_q, udr_d;

  logic                    frame_end_s, ready_s, clip_s;
  logic signed [SW-1:0]    fb_s, x_s, i1_ext_s, i2_ext_s, sum1_s, sum2_s, last_s, dith_s, q_s;
  logic [INT_W:0]          sat1_s, sat2_s;
  logic signed [INT_W-1:0] i1_nx_s, i2_nx_s;
  logic [DATA_W-1:0]       held_nx_s;

  assign frame_end_s = (cnt_q == LAST_CNT);
  assign ready_s     = frame_end_s & enable;

  // Frame counter and IDLE/RUN decision at the frame boundary.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    case (state_q)
      ST_IDLE: state_d = (frame_end_s && enable)  ? ST_RUN  : ST_IDLE;
      ST_RUN:  state_d = (frame_end_s && !enable) ? ST_IDLE : ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Modulator datapath, sample hold and sticky flags.
  always_comb begin
    fb_s     = out_q ? FB_POS : FB_NEG;
    x_s      = {{(SW-DATA_W){held_q[DATA_W-1]}}, held_q};
    i1_ext_s = {{2{i1_q[INT_W-1]}}, i1_q};
    i2_ext_s = {{2{i2_q[INT_W-1]}}, i2_q};
    sum1_s   = i1_ext_s + x_s - fb_s;
    sum2_s   = i2_ext_s + i1_ext_s - fb_s;
    sat1_s   = sat_f(sum1_s);
    sat2_s   = sat_f(sum2_s);
    dith_s   = DITHER_EN ? (lfsr_q[0] ? D_POS : D_NEG) : {SW{1'b0}};
    i1_nx_s  = i1_q;
    i2_nx_s  = i2_q;
    clip_s   = 1'b0;
    last_s   = {SW{1'b0}};
    q_s      = {SW{1'b0}};
    out_d    = ~out_q;
    lfsr_d   = lfsr_q;
    if (state_q == ST_RUN) begin
      i1_nx_s = sat1_s[INT_W-1:0];
      if (ORDER == 2) begin
        i2_nx_s = sat2_s[INT_W-1:0];
        clip_s  = sat1_s[INT_W] | sat2_s[INT_W];
        last_s  = {{2{sat2_s[INT_W-1]}}, sat2_s[INT_W-1:0]};
      end else begin
        i2_nx_s = {INT_W{1'b0}};
        clip_s  = sat1_s[INT_W];
        last_s  = {{2{sat1_s[INT_W-1]}}, sat1_s[INT_W-1:0]};
      end
      q_s    = last_s + dith_s;
      out_d  = ~q_s[SW-1];
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end else begin
      out_d  = ~out_q;
      lfsr_d = lfsr_q;
    end
    if (ready_s && in_valid) begin
      held_nx_s = in_data;
    end else begin
      held_nx_s = held_q;
    end
    // IDLE keeps the loop filter and held sample flushed for a clean restart.
    if (state_d == ST_IDLE) begin
      i1_d   = {INT_W{1'b0}};
      i2_d   = {INT_W{1'b0}};
      held_d = {DATA_W{1'b0}};
    end else begin
      i1_d   = i1_nx_s;
      i2_d   = i2_nx_s;
      held_d = held_nx_s;
    end
    if (flag_clr) begin
      ovl_d = 1'b0;
      udr_d = 1'b0;
    end else begin
      ovl_d = ovl_q | clip_s;
      udr_d = udr_q | (ready_s & ~in_valid);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      i1_q    <= {INT_W{1'b0}};
      i2_q    <= {INT_W{1'b0}};
      held_q  <= {DATA_W{1'b0}};
      lfsr_q  <= LFSR_SEED;
      out_q   <= 1'b0;
      ovl_q   <= 1'b0;
      udr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      held_q  <= held_d;
      lfsr_q  <= lfsr_d;
      out_q   <= out_d;
      ovl_q   <= ovl_d;
      udr_q   <= udr_d;
    end
  end

  assign in_ready = ready_s;
  assign out      = out_q;
  assign running  = (state_q == ST_RUN);
  assign overload = ovl_q;
  assign underrun = udr_q;

endmodule

// File: tb/tb_sdm_mod_param.sv
// Randomised bench for sdm_mod_param: two differently parametrised instances are
// compared every cycle against an arithmetic reference model, plus density and flag checks.
module tb_sdm_mod_param;

  localparam int AW = 16, AIW = 20, AOSR = 16, AORD = 1;
  localparam int BW = 8,  BIW = 9,  BOSR = 8,  BORD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, in_valid, flag_clr;
  logic [15:0] din_a;
  logic [7:0]  din_b;
  logic        rdy_a, out_a, run_a, ovl_a, udr_a;
  logic        rdy_b, out_b, run_b, ovl_b, udr_b;

  sdm_mod_param #(.DATA_W(AW), .ORDER(AORD), .INT_W(AIW), .OSR(AOSR),
                  .DITHER_EN(1'b1), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .reset(rst), .enable(enable), .in_data(din_a), .in_valid(in_valid),
    .in_ready(rdy_a), .out(out_a), .running(run_a), .overload(ovl_a),
    .underrun(udr_a), .flag_clr(flag_clr));

  sdm_mod_param #(.DATA_W(BW), .ORDER(BORD), .INT_W(BIW), .OSR(BOSR),
                  .DITHER_EN(1'b0), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .reset(rst), .enable(enable), .in_data(din_b), .in_valid(in_valid),
    .in_ready(rdy_b), .out(out_b), .running(run_b), .overload(ovl_b),
    .underrun(udr_b), .flag_clr(flag_clr));

  typedef struct {
    int          cnt;
    bit          run;
    longint      i1, i2, held;
    bit          o;
    bit [15:0]   lfsr;
    bit          ovl, udr;
  } ms_t;

  ms_t ma, mb;
  int  n_pass = 0, n_chk = 0;
  int  ones;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  function automatic ms_t m_reset();
    ms_t s;
    s.cnt = 0; s.run = 0; s.i1 = 0; s.i2 = 0; s.held = 0;
    s.o = 0; s.lfsr = 16'hACE1; s.ovl = 0; s.udr = 0;
    return s;
  endfunction

  function automatic bit m_ready(ms_t s, int osr, bit en);
    return (s.cnt == osr - 1) && en;
  endfunction

  function automatic longint clampv(longint v, int iw, inout bit clip);
    longint hi, lo;
    hi = (64'sd1 <<< (iw - 1)) - 1;
    lo = -(64'sd1 <<< (iw - 1));
    if (v > hi) begin clip = 1; return hi; end
    if (v < lo) begin clip = 1; return lo; end
    return v;
  endfunction

  // One clock of the modulator described directly from its arithmetic rules.
  function automatic ms_t m_step(ms_t s, int dw, int ord, int iw, int osr, bit dith,
                                 bit en, bit vld, bit clr, longint din);
    ms_t    n;
    bit     rdy, clip, nrun;
    longint fb, a, b, last, d;
    n = s; clip = 0;
    rdy = m_ready(s, osr, en);
    n.cnt = (s.cnt + 1) % osr;
    if (s.run) begin
      fb = s.o ? (64'sd1 <<< (dw - 1)) - 1 : -(64'sd1 <<< (dw - 1));
      a = clampv(s.i1 + s.held - fb, iw, clip);
      n.i1 = a; last = a;
      if (ord == 2) begin
        b = clampv(s.i2 + s.i1 - fb, iw, clip);
        n.i2 = b; last = b;
      end
      d = dith ? (s.lfsr[0] ? 64'sd1 : -64'sd1) : 64'sd0;
      n.o = (last + d) >= 0;
      n.lfsr = {^(s.lfsr & 16'h002D), s.lfsr[15:1]};
    end else begin
      n.o = !s.o;
    end
    n.ovl = clr ? 1'b0 : (clip ? 1'b1 : s.ovl);
    n.udr = clr ? 1'b0 : ((rdy && !vld) ? 1'b1 : s.udr);
    if (rdy && vld) n.held = din;
    nrun = (s.cnt == osr - 1) ? en : s.run;
    n.run = nrun;
    if (!nrun) begin n.i1 = 0; n.i2 = 0; n.held = 0; end
    return n;
  endfunction

  // Drive one cycle's inputs at the falling edge, compare both DUTs, then advance models.
  task automatic cycle(input bit en, input bit vld, input bit clr, input logic [15:0] d);
    enable = en; in_valid = vld; flag_clr = clr; din_a = d; din_b = d[15:8];
    #1;
    check("a_out", out_a, ma.o);
    check("a_running", run_a, ma.run);
    check("a_in_ready", rdy_a, m_ready(ma, AOSR, en));
    check("a_overload", ovl_a, ma.ovl);
    check("a_underrun", udr_a, ma.udr);
    check("b_out", out_b, mb.o);
    check("b_running", run_b, mb.run);
    check("b_in_ready", rdy_b, m_ready(mb, BOSR, en));
    check("b_overload", ovl_b, mb.ovl);
    check("b_underrun", udr_b, mb.udr);
    if (ma.run) ones += out_a;
    ma = m_step(ma, AW, AORD, AIW, AOSR, 1'b1, en, vld, clr, longint'($signed(din_a)));
    mb = m_step(mb, BW, BORD, BIW, BOSR, 1'b0, en, vld, clr, longint'($signed(din_b)));
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_a"}, out_a, 0);  check({tag, "_rdy_a"}, rdy_a, 0);
    check({tag, "_run_a"}, run_a, 0);  check({tag, "_ovl_a"}, ovl_a, 0);
    check({tag, "_udr_a"}, udr_a, 0);  check({tag, "_out_b"}, out_b, 0);
    check({tag, "_run_b"}, run_b, 0);  check({tag, "_ovl_b"}, ovl_b, 0);
  endtask

  task automatic density(input logic [15:0] d, input int n, input int lo, input int hi,
                         input string tag);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, d);
    ones = 0;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, d);
    check($sformatf("%s ones=%0d", tag, ones), (ones >= lo && ones <= hi), 1);
  endtask

  initial begin
    bit en;
    bit found;
    int r;
    logic [15:0] d;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; flag_clr = 1'b0;
    din_a = 16'h0000; din_b = 8'h00; ones = 0;
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    ma = m_reset(); mb = m_reset();

    // Idle pattern with enable low.
    for (int i = 0; i < 64; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Density at zero, +half and -half scale.
    density(16'h0000, 4096, 2046, 2050, "dens_zero");
    check("dens_zero_udr", udr_a, 0);
    density(16'h4000, 8192, 6103, 6185, "dens_pos_half");
    density(16'hC000, 8192, 2007, 2089, "dens_neg_half");

    // One dropped frame in a 0x2000 stream, then clear.
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 1'b0, 16'h2000);
    for (int i = 0; i < AOSR; i++) cycle(1'b1, 1'b0, 1'b0, 16'h5555);
    check("udr_set_a", udr_a, 1);
    check("udr_set_b", udr_b, 1);
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 1'b0, 16'h2000);
    cycle(1'b1, 1'b1, 1'b1, 16'h2000);
    check("udr_clr_a", udr_a, 0);

    // Full-scale input drives the narrow integrators into saturation.
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 1'b0, 16'h7FFF);
    check("ovl_set_b", ovl_b, 1);
    cycle(1'b1, 1'b1, 1'b1, 16'h7FFF);
    check("ovl_clr_b", ovl_b, 0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0000);

    // Enable dropped mid-frame: RUN lasts to the frame end.
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (ma.cnt == 10) found = 1'b1;
      else cycle(1'b1, 1'b1, 1'b0, 16'h1000);
    end
    check("cnt10_reached", found, 1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 16'h1000);
    check("run_holds_a", run_a, 1);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'b0, 16'h1000);
    check("idle_after_a", run_a, 0);

    // Randomised traffic.
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      r = $urandom_range(0, 3);
      d = (r == 0) ? 16'h7FFF : (r == 1) ? 16'h8000 : 16'($urandom);
      cycle(en, $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0, d);
    end

    // Asynchronous reset in the middle of a running frame.
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 16'h7FFF);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    ma = m_reset(); mb = m_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdm_mod_param.md
Name: sdm_mod_param

Overview:
Parametrised successor to the team's fixed second-order 1-bit PDM modulator.
- Converts DATA_W-bit signed samples from the interpolation filter into a 1-bit PDM stream at the oversampled clock.
- Adds selectable order (1 or 2), saturating integrators with overload reporting, optional LFSR dither, and a per-frame ready/valid sample handshake with underrun detection.
- Adds an enable-driven IDLE/RUN state machine with a zero-mean idle pattern.

Parameters:
DATA_W, 16, input sample width (signed two's complement), 8..24
ORDER, 2, modulator order, 1 or 2 only
INT_W, DATA_W+4, integrator width (signed)
OSR, 128, modulator clocks per input sample, power of two, 4..1024
DITHER_EN, 1, 1 = add LFSR dither to quantiser input
LFSR_SEED, 16'hACE1, non-zero reset value of dither LFSR

Ports:
clk  in  1  oversampled modulator clock
reset  in  1  asynchronous active-high reset
enable  in  1  1 = run modulator, 0 = return to IDLE at next frame boundary
in_data  in  DATA_W  signed input sample
in_valid  in  1  in_data valid
in_ready  out  1  block accepts a sample this cycle
out  out  1  PDM output bit (registered)
running  out  1  1 while state = RUN
overload  out  1  sticky: an integrator saturated since last clear
underrun  out  1  sticky: in_valid low when in_ready high during RUN
flag_clr  in  1  synchronous clear of overload and underrun (wins over a same-cycle set)

Behaviour:
Reset (async, active-high):
- state=IDLE; frame counter=0; integrators=0; held sample=0; LFSR=LFSR_SEED.
- out=0, in_ready=0, running=0, overload=0, underrun=0.

Frame counter: counts 0..OSR-1 and wraps, in both states.

in_ready:
- High for exactly one clk when counter==OSR-1 and the next state is RUN.
- Otherwise low.

Sample acceptance:
- in_valid & in_ready: in_data latched into held sample at that edge.
- in_ready & !in_valid: held sample unchanged, underrun set.
- In_valid while in_ready is low is ignored; no back-pressure.

State machine:
- IDLE -> RUN: enable=1 at counter==OSR-1. The first sample is accepted on that same edge.
- RUN -> IDLE: enable=0 at counter==OSR-1.
- Enable changes at any other count take effect only at the frame boundary.

IDLE:
- Integrators held at 0, held sample cleared to 0.
- out toggles every clk (1,0,1,0,...), giving zero mean.
- LFSR frozen.

RUN, per clk:
- fb = out ? +(2^(DATA_W-1)-1) : -2^(DATA_W-1), sign-extended to INT_W.
- x = held sample sign-extended to INT_W.
- i1_next = sat(i1 + x - fb).
- ORDER=2 only: i2_next = sat(i2 + i1 - fb), using the old i1.
- q = last integrator (i1 for ORDER=1, i2 for ORDER=2) + d.
  - d = +1 or -1 from LFSR bit0 when DITHER_EN=1, else 0.
- out_next = (q >= 0), computed at INT_W+1 bits.
- Latency: held sample change affects out on the next clk edge.

Saturation:
- sat() clamps to [-2^(INT_W-1), 2^(INT_W-1)-1].
- Any clamp in a cycle sets overload.

Dither LFSR:
- 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
- Advances once per clk in RUN only.
- Never reaches 0.

Flags:
- overload and underrun are sticky.
- flag_clr clears both; a clear in the same cycle as a set leaves the flag 0.

Other boundary rules:
- Reset mid-RUN returns to IDLE immediately (async).
- DATA_W to INT_W growth uses sign-extension only; no truncation of the input.

Test Plan:
1. Reset, then enable=0 for 64 clks -> out toggles 1,0,1,0; in_ready, running, overload, underrun all 0.
2. ORDER=2, DITHER_EN=0, enable=1, in_data=0 supplied every frame -> running rises at the first boundary; ones-density over 4096 RUN clks is 2048±2; underrun stays 0.
3. in_data=16'sh4000 every frame -> ones-density over 8192 clks is 75%±0.5%. Repeat with in_data=-16'sh4000 -> 25%±0.5%.
4. Valid dropped for 1 frame during a 0x2000 stream -> underrun sets on the missed in_ready cycle; held sample stays 0x2000; density unchanged. flag_clr -> underrun=0.
5. INT_W=DATA_W+1, in_data=16'sh7FFF held for 2 frames -> overload sets; integrators stay within bounds (checker on internal ranges); out remains mostly 1. flag_clr asserted in the same cycle as a saturation -> overload reads 0 the next cycle.
6. enable dropped at counter=10 -> RUN continues to counter=OSR-1, then IDLE. Async reset asserted mid-frame -> all outputs 0 within the same cycle; integrators 0.
